// File: rtl/dual_port_mem_responder.sv
// ----------------------------------------------------------------------------
// Module  : dual_port_mem_responder
// Purpose : Dual-port word memory that answers memory_interface I/D requests.
//           Build option DUAL_PORT_MEM_FORWARD_EN: same-edge I-read sees D-write.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dual_port_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_mem_read,
  input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
  output logic [DATA_WIDTH-1:0]     i_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
  output logic                      i_mem_valid,
  output logic                      i_mem_ready,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      d_mem_valid,
  output logic                      d_mem_ready
);

  localparam int         c_lanes    = DATA_WIDTH / 8;
  localparam int         c_depth    = 1 << INDEX_BITS;
  localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [c_depth];

  state_t                  i_state_q, d_state_q;
  logic [3:0]              i_cnt_q, d_cnt_q;
  logic                    i_valid_q, d_valid_q;
  logic                    i_ready_q, d_ready_q;
  logic [DATA_WIDTH-1:0]   i_pend_data_q, d_pend_data_q;
  logic [DATA_WIDTH-1:0]   i_data_out_q, d_data_out_q;
  logic [ADDRESS_BITS-1:0] i_pend_addr_q, d_pend_addr_q;
  logic [ADDRESS_BITS-1:0] i_addr_out_q, d_addr_out_q;

  logic [INDEX_BITS-1:0]   i_idx, d_idx;
  logic                    i_accept, d_accept, d_wr_accept;
  logic [DATA_WIDTH-1:0]   d_old, d_merged, d_word, i_word;

  assign i_idx       = i_mem_address_in[INDEX_BITS+1:2];
  assign d_idx       = d_mem_address_in[INDEX_BITS+1:2];
  assign i_accept    = i_ready_q & i_mem_read;
  assign d_accept    = d_ready_q & (d_mem_read | d_mem_write);
  assign d_wr_accept = d_accept & d_mem_write;
  assign d_old       = mem_q[d_idx];
  assign d_word      = d_mem_write ? d_merged : d_old;

  always_comb begin
    d_merged = d_old;
    for (int k = 0; k < c_lanes; k++) begin
      if (d_mem_byte_en[k]) d_merged[8*k +: 8] = d_mem_data_in[8*k +: 8];
    end
  end

`ifdef DUAL_PORT_MEM_FORWARD_EN
  // Same-edge data write to the fetched word is forwarded to the fetch.
  assign i_word = (d_wr_accept && (d_idx == i_idx)) ? d_merged : mem_q[i_idx];
`else
  assign i_word = mem_q[i_idx];
`endif

  always_ff @(posedge clock) begin
    if (d_wr_accept) mem_q[d_idx] <= d_merged;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_state_q     <= ST_IDLE;
      i_cnt_q       <= '0;
      i_valid_q     <= 1'b0;
      i_ready_q     <= 1'b0;
      i_pend_data_q <= '0;
      i_pend_addr_q <= '0;
      i_data_out_q  <= '0;
      i_addr_out_q  <= '0;
    end else begin
      i_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
      case (i_state_q)
        ST_BUSY: begin
          if (i_cnt_q == 4'd1) begin
            i_state_q    <= ST_RESP;
            i_valid_q    <= 1'b1;
            i_data_out_q <= i_pend_data_q;
            i_addr_out_q <= i_pend_addr_q;
          end else begin
            i_cnt_q   <= i_cnt_q - 4'd1;
            i_ready_q <= 1'b0;
          end
        end
        default: begin
          if (i_accept) begin
            i_pend_data_q <= i_word;
            i_pend_addr_q <= i_mem_address_in;
            if (LATENCY == 1) begin
              i_state_q    <= ST_RESP;
              i_valid_q    <= 1'b1;
              i_data_out_q <= i_word;
              i_addr_out_q <= i_mem_address_in;
            end else begin
              i_state_q <= ST_BUSY;
              i_cnt_q   <= c_lat_load;
              i_ready_q <= 1'b0;
            end
          end else begin
            i_state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_state_q     <= ST_IDLE;
      d_cnt_q       <= '0;
      d_valid_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      d_pend_data_q <= '0;
      d_pend_addr_q <= '0;
      d_data_out_q  <= '0;
      d_addr_out_q  <= '0;
    end else begin
      d_valid_q <= 1'b0;
      d_ready_q <= 1'b1;
      case (d_state_q)
        ST_BUSY: begin
          if (d_cnt_q == 4'd1) begin
            d_state_q    <= ST_RESP;
            d_valid_q    <= 1'b1;
            d_data_out_q <= d_pend_data_q;
            d_addr_out_q <= d_pend_addr_q;
          end else begin
            d_cnt_q   <= d_cnt_q - 4'd1;
            d_ready_q <= 1'b0;
          end
        end
        default: begin
          if (d_accept) begin
            d_pend_data_q <= d_word;
            d_pend_addr_q <= d_mem_address_in;
            if (LATENCY == 1) begin
              d_state_q    <= ST_RESP;
              d_valid_q    <= 1'b1;
              d_data_out_q <= d_word;
              d_addr_out_q <= d_mem_address_in;
            end else begin
              d_state_q <= ST_BUSY;
              d_cnt_q   <= c_lat_load;
              d_ready_q <= 1'b0;
            end
          end else begin
            d_state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign i_mem_data_out    = i_data_out_q;
  assign i_mem_address_out = i_addr_out_q;
  assign i_mem_valid       = i_valid_q;
  assign i_mem_ready       = i_ready_q;
  assign d_mem_data_out    = d_data_out_q;
  assign d_mem_address_out = d_addr_out_q;
  assign d_mem_valid       = d_valid_q;
  assign d_mem_ready       = d_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_mem_responder.sv
// ----------------------------------------------------------------------------
// Module  : tb_dual_port_mem_responder
// Purpose : Directed bench for dual_port_mem_responder, LATENCY=1 and LATENCY=4.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dual_port_mem_responder;

  logic clk;
  logic rst_n;

  // Instance A: LATENCY=1
  logic        a_i_read;
  logic [31:0] a_i_addr;
  logic [31:0] a_i_dout, a_i_aout;
  logic        a_i_valid, a_i_ready;
  logic        a_d_read, a_d_write;
  logic [3:0]  a_d_be;
  logic [31:0] a_d_addr, a_d_din;
  logic [31:0] a_d_dout, a_d_aout;
  logic        a_d_valid, a_d_ready;

  // Instance B: LATENCY=4
  logic        b_i_read;
  logic [31:0] b_i_addr;
  logic [31:0] b_i_dout, b_i_aout;
  logic        b_i_valid, b_i_ready;
  logic        b_d_read, b_d_write;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_addr, b_d_din;
  logic [31:0] b_d_dout, b_d_aout;
  logic        b_d_valid, b_d_ready;

  int checks;
  int failures;

  dual_port_mem_responder #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .INDEX_BITS(10), .LATENCY(1)
  ) u_a (
    .clock(clk), .reset(rst_n),
    .i_mem_read(a_i_read), .i_mem_address_in(a_i_addr),
    .i_mem_data_out(a_i_dout), .i_mem_address_out(a_i_aout),
    .i_mem_valid(a_i_valid), .i_mem_ready(a_i_ready),
    .d_mem_read(a_d_read), .d_mem_write(a_d_write), .d_mem_byte_en(a_d_be),
    .d_mem_address_in(a_d_addr), .d_mem_data_in(a_d_din),
    .d_mem_data_out(a_d_dout), .d_mem_address_out(a_d_aout),
    .d_mem_valid(a_d_valid), .d_mem_ready(a_d_ready)
  );

  dual_port_mem_responder #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .INDEX_BITS(10), .LATENCY(4)
  ) u_b (
    .clock(clk), .reset(rst_n),
    .i_mem_read(b_i_read), .i_mem_address_in(b_i_addr),
    .i_mem_data_out(b_i_dout), .i_mem_address_out(b_i_aout),
    .i_mem_valid(b_i_valid), .i_mem_ready(b_i_ready),
    .d_mem_read(b_d_read), .d_mem_write(b_d_write), .d_mem_byte_en(b_d_be),
    .d_mem_address_in(b_d_addr), .d_mem_data_in(b_d_din),
    .d_mem_data_out(b_d_dout), .d_mem_address_out(b_d_aout),
    .d_mem_valid(b_d_valid), .d_mem_ready(b_d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_fwd;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_i_read = 0; a_i_addr = 0; a_d_read = 0; a_d_write = 0; a_d_be = 0; a_d_addr = 0; a_d_din = 0;
    b_i_read = 0; b_i_addr = 0; b_d_read = 0; b_d_write = 0; b_d_be = 0; b_d_addr = 0; b_d_din = 0;

    // Reset held for three cycles
    tick(); tick(); tick();
    chk("rst_a_i_valid", {31'd0, a_i_valid}, 32'd0);
    chk("rst_a_d_valid", {31'd0, a_d_valid}, 32'd0);
    chk("rst_a_i_ready", {31'd0, a_i_ready}, 32'd0);
    chk("rst_a_d_ready", {31'd0, a_d_ready}, 32'd0);
    chk("rst_a_d_dout",  a_d_dout, 32'd0);
    chk("rst_a_i_aout",  a_i_aout, 32'd0);
    chk("rst_b_d_ready", {31'd0, b_d_ready}, 32'd0);
    chk("rst_b_d_aout",  b_d_aout, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_a_i_ready", {31'd0, a_i_ready}, 32'd1);
    chk("rel_a_d_ready", {31'd0, a_d_ready}, 32'd1);
    chk("rel_b_i_ready", {31'd0, b_i_ready}, 32'd1);
    chk("rel_b_d_ready", {31'd0, b_d_ready}, 32'd1);

    // Full-word write then read back, LATENCY=1
    a_d_write = 1; a_d_addr = 32'h12341234; a_d_din = 32'h99999999; a_d_be = 4'hF;
    tick();
    a_d_write = 0;
    chk("wr_valid", {31'd0, a_d_valid}, 32'd1);
    chk("wr_aout",  a_d_aout, 32'h12341234);
    chk("wr_dout",  a_d_dout, 32'h99999999);
    tick();
    chk("wr_valid_drop", {31'd0, a_d_valid}, 32'd0);
    chk("wr_aout_hold",  a_d_aout, 32'h12341234);
    a_d_read = 1;
    tick();
    a_d_read = 0;
    chk("rd_valid", {31'd0, a_d_valid}, 32'd1);
    chk("rd_dout",  a_d_dout, 32'h99999999);
    tick();

    // Byte lanes, back-to-back at LATENCY=1
    a_d_write = 1; a_d_addr = 32'h0; a_d_din = 32'hAABBCCDD; a_d_be = 4'hF;
    tick();
    chk("bl_w1_valid", {31'd0, a_d_valid}, 32'd1);
    a_d_din = 32'h11223344; a_d_be = 4'b0101;
    tick();
    chk("bl_w2_valid", {31'd0, a_d_valid}, 32'd1);
    chk("bl_w2_merged", a_d_dout, 32'hAA22CC44);
    a_d_write = 0; a_d_read = 1;
    tick();
    a_d_read = 0;
    chk("bl_rd_valid", {31'd0, a_d_valid}, 32'd1);
    chk("bl_rd_dout",  a_d_dout, 32'hAA22CC44);
    tick();

    // Wrap and same-edge I-read / D-write to word 0
`ifdef DUAL_PORT_MEM_FORWARD_EN
    exp_fwd = 32'h10002000;
`else
    exp_fwd = 32'hAA22CC44;
`endif
    a_d_write = 1; a_d_addr = 32'h00001000; a_d_din = 32'h10002000; a_d_be = 4'hF;
    a_i_read = 1; a_i_addr = 32'h0;
    tick();
    a_d_write = 0; a_i_read = 0;
    chk("cc_i_valid", {31'd0, a_i_valid}, 32'd1);
    chk("cc_i_dout",  a_i_dout, exp_fwd);
    chk("cc_i_aout",  a_i_aout, 32'h0);
    chk("cc_d_aout",  a_d_aout, 32'h00001000);
    a_d_read = 1; a_d_addr = 32'h0;
    tick();
    a_d_read = 0;
    chk("wrap_rd_dout", a_d_dout, 32'h10002000);
    tick();

    // LATENCY=4 data write
    b_d_write = 1; b_d_addr = 32'h40; b_d_din = 32'hCAFEF00D; b_d_be = 4'hF;
    tick();
    b_d_write = 0;
    chk("l4w_ready_n0", {31'd0, b_d_ready}, 32'd0);
    tick();
    chk("l4w_valid_n1", {31'd0, b_d_valid}, 32'd0);
    tick();
    chk("l4w_ready_n2", {31'd0, b_d_ready}, 32'd0);
    tick();
    chk("l4w_valid_n3", {31'd0, b_d_valid}, 32'd1);
    chk("l4w_dout_n3",  b_d_dout, 32'hCAFEF00D);
    tick();
    chk("l4w_valid_n4", {31'd0, b_d_valid}, 32'd0);

    // LATENCY=4 instruction read with a held follow-up request
    b_i_read = 1; b_i_addr = 32'h11111111;
    tick();
    b_i_addr = 32'h22222220;
    chk("l4i_ready_n0", {31'd0, b_i_ready}, 32'd0);
    chk("l4i_valid_n0", {31'd0, b_i_valid}, 32'd0);
    tick();
    chk("l4i_ready_n1", {31'd0, b_i_ready}, 32'd0);
    chk("l4i_valid_n1", {31'd0, b_i_valid}, 32'd0);
    tick();
    chk("l4i_ready_n2", {31'd0, b_i_ready}, 32'd0);
    chk("l4i_valid_n2", {31'd0, b_i_valid}, 32'd0);
    tick();
    chk("l4i_valid_n3", {31'd0, b_i_valid}, 32'd1);
    chk("l4i_ready_n3", {31'd0, b_i_ready}, 32'd1);
    chk("l4i_aout_n3",  b_i_aout, 32'h11111111);
    tick();
    b_i_read = 0;
    chk("l4i_valid_n4", {31'd0, b_i_valid}, 32'd0);
    chk("l4i_ready_n4", {31'd0, b_i_ready}, 32'd0);
    chk("l4i_aout_hold", b_i_aout, 32'h11111111);
    tick(); tick();
    chk("l4i2_valid_early", {31'd0, b_i_valid}, 32'd0);
    tick();
    chk("l4i2_valid", {31'd0, b_i_valid}, 32'd1);
    chk("l4i2_aout",  b_i_aout, 32'h22222220);
    tick();
    chk("l4i2_valid_drop", {31'd0, b_i_valid}, 32'd0);

    // Reset during BUSY drops the response
    b_d_read = 1; b_d_addr = 32'h40;
    tick();
    b_d_read = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_ready", {31'd0, b_d_ready}, 32'd0);
    chk("mr_dout",  b_d_dout, 32'd0);
    tick();
    chk("mr_valid_a", {31'd0, b_d_valid}, 32'd0);
    tick();
    chk("mr_valid_b", {31'd0, b_d_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_valid_c", {31'd0, b_d_valid}, 32'd0);
    chk("mr_ready_back", {31'd0, b_d_ready}, 32'd1);
    b_d_read = 1; b_d_addr = 32'h40;
    a_d_read = 1; a_d_addr = 32'h0;
    tick();
    b_d_read = 0; a_d_read = 0;
    chk("mr_a_dout", a_d_dout, 32'h10002000);
    tick(); tick();
    chk("mr_b_valid_early", {31'd0, b_d_valid}, 32'd0);
    tick();
    chk("mr_b_valid", {31'd0, b_d_valid}, 32'd1);
    chk("mr_b_dout",  b_d_dout, 32'hCAFEF00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dual_port_mem_responder.md
# dual_port_mem_responder

Word-addressed dual-port memory that serves the instruction-side and data-side request ports of `memory_interface`, acting as the responder end of its valid/ready protocol. Port names match `memory_interface` so both instances connect wire-for-wire. Each port has its own request acceptance, configurable-latency response FSM and echo of the request address, and both ports share one storage array. This block replaces the ideal BRAM in core-level benches and small FPGA builds.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `ADDRESS_BITS`, 32: byte-address width.
- `INDEX_BITS`, 10: log2 of the word count. 1024 words by default.
- `LATENCY`, 1: number of cycles from request acceptance to `*_valid`. Legal range is 1–15.

Ports:
- `clock`  in  1  single clock domain, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_mem_read`  in  1  instruction read request.
- `i_mem_address_in`  in  ADDRESS_BITS  instruction byte address.
- `i_mem_data_out`  out  DATA_WIDTH  instruction read data.
- `i_mem_address_out`  out  ADDRESS_BITS  echo of the accepted instruction address.
- `i_mem_valid`  out  1  instruction response strobe.
- `i_mem_ready`  out  1  instruction port can accept a request.
- `d_mem_read`  in  1  data read request.
- `d_mem_write`  in  1  data write request.
- `d_mem_byte_en`  in  DATA_WIDTH/8  write byte lanes.
- `d_mem_address_in`  in  ADDRESS_BITS  data byte address.
- `d_mem_data_in`  in  DATA_WIDTH  write data.
- `d_mem_data_out`  out  DATA_WIDTH  read data, or the merged word on a write.
- `d_mem_address_out`  out  ADDRESS_BITS  echo of the accepted data address.
- `d_mem_valid`  out  1  data response strobe.
- `d_mem_ready`  out  1  data port can accept a request.

## Operation
- Word index is `address[INDEX_BITS+1:2]`. Bits `[1:0]` and bits above the index are ignored, so addresses wrap modulo the array size.
- Each port runs an independent FSM with states IDLE, BUSY and RESP.
  - Acceptance: on a rising edge where `ready`=1 and a request is present. Request is `i_mem_read` on the instruction port, `d_mem_read|d_mem_write` on the data port.
  - On acceptance the FSM captures the address. It goes to RESP if `LATENCY`=1, otherwise to BUSY with the counter loaded to `LATENCY-1`.
  - BUSY: decrements the counter and goes to RESP when the counter reaches 1.
  - RESP: `valid`=1 for exactly one cycle. A new request in RESP is accepted (back-to-back); otherwise the FSM returns to IDLE.
- `ready` is 1 in IDLE and RESP, and 0 in BUSY.
- Reads sample the array at the acceptance edge. Data is held in a register and presented during RESP.
- Writes update the array at the acceptance edge, only for lanes with `d_mem_byte_en[k]`=1. The response presents the merged word.
- If `d_mem_read` and `d_mem_write` are both high, the request is treated as a write; `d_mem_read` is ignored.
- Request inputs are ignored while `ready`=0. The requester must hold them until accepted.
- Array contents are not affected by reset.

## Timing
- Reset (asynchronous assert):
  - all `*_valid`, `*_data_out` and `*_address_out` go to 0.
  - both `*_ready` go to 0.
  - both FSMs go to IDLE.
- After reset deasserts, `*_ready` rises at the first rising edge.
- `data_out` and `address_out` hold their last values outside RESP.
- Response timing: request accepted at edge N gives `valid` high from edge N+LATENCY-1 to edge N+LATENCY.
  - With `LATENCY`=1 this is the cycle after acceptance.
  - With `LATENCY`=1, back-to-back acceptance gives one response per cycle.
- Reset asserted mid-transaction: the pending response is dropped and no `valid` is issued. A write already accepted remains in the array.
- Same-edge instruction read and data write to the same word: the instruction port returns the old word unless forwarding is compiled in (see Configuration).
- Same-edge writes to the same word cannot occur, because the instruction port is read-only.

## Configuration
- Macro: `DUAL_PORT_MEM_FORWARD_EN`.
- Defined: an instruction read accepted on the same edge as a data write to the same word returns the post-write merged word.
- Undefined: that instruction read returns the pre-write word (read-before-write). No comparison logic is built.

## Test plan
- **Reset and ready:** hold `reset`=0 for 3 cycles, then release.
  - During reset: all outputs 0.
  - At the first edge after release: `i_mem_ready`=`d_mem_ready`=1.
- **Write, then read back (`LATENCY`=1):**
  - Write 32'h99999999 to 32'h12341234 with `byte_en`=4'hF: `d_mem_valid` pulses for 1 cycle, `d_mem_address_out`=32'h12341234.
  - Then read 32'h12341234: `d_mem_data_out`=32'h99999999.
- **Byte lanes:**
  - Write 32'hAABBCCDD to word 0, then write 32'h11223344 with `byte_en`=4'b0101.
  - Read of word 0 returns 32'hAA22CC44.
- **Multi-cycle latency (`LATENCY`=4):**
  - Instruction read of 32'h11111111 accepted at edge N: `i_mem_ready`=0 for 3 cycles, `i_mem_valid` high only during cycle N+3, `i_mem_address_out`=32'h11111111.
  - A second request held from N+1 is accepted at edge N+4.
- **Wrap and concurrency:**
  - Write 32'h10002000 to byte address 32'h00001000 (index 0, wraps with `INDEX_BITS`=10).
  - On the same edge, read word 0 on the instruction port: returns the old word without the macro, 32'h10002000 with `DUAL_PORT_MEM_FORWARD_EN`.
- **Reset mid-operation (`LATENCY`=4):** assert `reset` during BUSY.
  - No `valid` is issued.
  - After release, a read of the previously written word returns the retained data.
